// File: rtl/harris_pkg.sv
// Shared widths, typedefs and arithmetic helpers for the Harris corner pipeline.
package harris_pkg;

  localparam int PIX_W    = 8;
  localparam int GRAD_W   = 11;
  localparam int PROD_W   = 20;
  localparam int SUM_W    = 24;
  localparam int SXY_W    = 25;
  localparam int WIN_SIZE = 6;
  localparam int N_INT    = WIN_SIZE - 2;

  typedef logic [PIX_W-1:0]           pix_t;
  typedef logic signed [GRAD_W-1:0]   grad_t;
  typedef logic [PROD_W-1:0]          prod_sq_t;
  typedef logic signed [PROD_W:0]     prod_xy_t;
  typedef logic [SUM_W-1:0]           sum_sq_t;
  typedef logic signed [SXY_W-1:0]    sum_xy_t;
  typedef logic signed [2*GRAD_W-1:0] grad_wide_t;

  typedef struct packed {
    sum_sq_t sxx;
    sum_sq_t syy;
    sum_xy_t sxy;
  } tensor_t;

  // Operands are widened before multiplying; |g| <= 1020 so the square always fits PROD_W.
  function automatic prod_sq_t grad_sq(input grad_t g);
    return PROD_W'(grad_wide_t'(g) * grad_wide_t'(g));
  endfunction

  function automatic prod_xy_t grad_mul(input grad_t a, input grad_t b);
    return (PROD_W+1)'(grad_wide_t'(a) * grad_wide_t'(b));
  endfunction

endpackage

// File: rtl/sobel_3x3.sv
// Combinational 3x3 Sobel operator; pix[i][j] with i=0 the top line, j=0 the left column.
module sobel_3x3
  import harris_pkg::*;
(
  input  logic [2:0][2:0][PIX_W-1:0] pix,
  output grad_t                      ix,
  output grad_t                      iy
);

  grad_t left_sum;
  grad_t right_sum;
  grad_t top_sum;
  grad_t bottom_sum;

  always_comb begin
    left_sum   = grad_t'(pix[0][0]) + (grad_t'(pix[1][0]) << 1) + grad_t'(pix[2][0]);
    right_sum  = grad_t'(pix[0][2]) + (grad_t'(pix[1][2]) << 1) + grad_t'(pix[2][2]);
    top_sum    = grad_t'(pix[0][0]) + (grad_t'(pix[0][1]) << 1) + grad_t'(pix[0][2]);
    bottom_sum = grad_t'(pix[2][0]) + (grad_t'(pix[2][1]) << 1) + grad_t'(pix[2][2]);
    ix         = right_sum - left_sum;
    iy         = bottom_sum - top_sum;
  end

endmodule

// File: rtl/harris_gradient_tensor.sv
// Four-stage structure-tensor pipeline: Sobel gradients, products, row sums, final sums,
// plus raster-position tracking of the tensor on the output.
module harris_gradient_tensor
  import harris_pkg::*;
#(
  parameter int WIN_PER_LINE = 474,
  parameter int ROWS_OUT     = 475
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][PIX_W-1:0] window,
  input  logic                                         window_valid,
  output logic [SUM_W-1:0]                             sxx,
  output logic [SUM_W-1:0]                             syy,
  output logic signed [SXY_W-1:0]                      sxy,
  output logic                                         tensor_valid,
  output logic [8:0]                                   out_col,
  output logic [8:0]                                   out_row,
  output logic                                         frame_done
);

  localparam logic [8:0] LAST_COL = 9'(WIN_PER_LINE - 1);
  localparam logic [8:0] LAST_ROW = 9'(ROWS_OUT - 1);

  grad_t    ix_c  [N_INT][N_INT];
  grad_t    iy_c  [N_INT][N_INT];
  grad_t    ix_s1 [N_INT][N_INT];
  grad_t    iy_s1 [N_INT][N_INT];
  prod_sq_t xx_s2 [N_INT][N_INT];
  prod_sq_t yy_s2 [N_INT][N_INT];
  prod_xy_t xy_s2 [N_INT][N_INT];
  sum_sq_t  xx_row_c [N_INT];
  sum_sq_t  yy_row_c [N_INT];
  sum_xy_t  xy_row_c [N_INT];
  sum_sq_t  xx_s3 [N_INT];
  sum_sq_t  yy_s3 [N_INT];
  sum_xy_t  xy_s3 [N_INT];
  tensor_t  total_c;
  logic     valid_s1, valid_s2, valid_s3;

  // One Sobel per interior position, fed by its 3x3 neighbourhood.
  for (genvar r = 1; r <= N_INT; r++) begin : g_row
    for (genvar c = 1; c <= N_INT; c++) begin : g_col
      logic [2:0][2:0][PIX_W-1:0] nb;
      for (genvar i = 0; i < 3; i++) begin : g_nb_row
        for (genvar j = 0; j < 3; j++) begin : g_nb_col
          assign nb[i][j] = window[r-1+i][c-1+j];
        end
      end
      sobel_3x3 u_sobel (
        .pix (nb),
        .ix  (ix_c[r-1][c-1]),
        .iy  (iy_c[r-1][c-1])
      );
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N_INT; r++) begin
        for (int c = 0; c < N_INT; c++) begin
          ix_s1[r][c] <= '0;
          iy_s1[r][c] <= '0;
          xx_s2[r][c] <= '0;
          yy_s2[r][c] <= '0;
          xy_s2[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N_INT; r++) begin
        for (int c = 0; c < N_INT; c++) begin
          ix_s1[r][c] <= ix_c[r][c];
          iy_s1[r][c] <= iy_c[r][c];
          xx_s2[r][c] <= grad_sq(ix_s1[r][c]);
          yy_s2[r][c] <= grad_sq(iy_s1[r][c]);
          xy_s2[r][c] <= grad_mul(ix_s1[r][c], iy_s1[r][c]);
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N_INT; r++) begin
      xx_row_c[r] = '0;
      yy_row_c[r] = '0;
      xy_row_c[r] = '0;
      for (int c = 0; c < N_INT; c++) begin
        xx_row_c[r] = xx_row_c[r] + SUM_W'(xx_s2[r][c]);
        yy_row_c[r] = yy_row_c[r] + SUM_W'(yy_s2[r][c]);
        xy_row_c[r] = xy_row_c[r] + SXY_W'(xy_s2[r][c]);
      end
    end
  end

  always_comb begin
    total_c = '0;
    for (int r = 0; r < N_INT; r++) begin
      total_c.sxx = total_c.sxx + xx_s3[r];
      total_c.syy = total_c.syy + yy_s3[r];
      total_c.sxy = total_c.sxy + xy_s3[r];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N_INT; r++) begin
        xx_s3[r] <= '0;
        yy_s3[r] <= '0;
        xy_s3[r] <= '0;
      end
      sxx <= '0;
      syy <= '0;
      sxy <= '0;
    end else begin
      for (int r = 0; r < N_INT; r++) begin
        xx_s3[r] <= xx_row_c[r];
        yy_s3[r] <= yy_row_c[r];
        xy_s3[r] <= xy_row_c[r];
      end
      sxx <= total_c.sxx;
      syy <= total_c.syy;
      sxy <= total_c.sxy;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_s1     <= 1'b0;
      valid_s2     <= 1'b0;
      valid_s3     <= 1'b0;
      tensor_valid <= 1'b0;
    end else begin
      valid_s1     <= window_valid;
      valid_s2     <= valid_s1;
      valid_s3     <= valid_s2;
      tensor_valid <= valid_s3;
    end
  end

  // Position of the presented tensor; it steps once that tensor has been consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_col <= '0;
      out_row <= '0;
    end else if (tensor_valid) begin
      if (out_col == LAST_COL) begin
        out_col <= '0;
        out_row <= (out_row == LAST_ROW) ? 9'd0 : out_row + 9'd1;
      end else begin
        out_col <= out_col + 9'd1;
      end
    end
  end

  assign frame_done = tensor_valid && (out_col == LAST_COL) && (out_row == LAST_ROW);

endmodule

// File: tb/tb_harris_gradient_tensor.sv
// Randomised self-checking bench for harris_gradient_tensor against a plain-arithmetic model.
module tb_harris_gradient_tensor;

  localparam int TB_COLS = 12;
  localparam int TB_ROWS = 6;
  localparam int LAT     = 4;

  typedef logic [5:0][5:0][7:0] win_t;

  typedef struct {
    int     due;
    longint xx;
    longint yy;
    longint xy;
    int     col;
    int     row;
    bit     fd;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  win_t              window;
  logic              window_valid;
  logic [23:0]       sxx;
  logic [23:0]       syy;
  logic signed [24:0] sxy;
  logic              tensor_valid;
  logic [8:0]        out_col;
  logic [8:0]        out_row;
  logic              frame_done;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   fd_seen = 0;
  bit   checking = 1'b0;
  int   pos_col = 0;
  int   pos_row = 0;
  exp_t expq[$];

  harris_gradient_tensor #(
    .WIN_PER_LINE (TB_COLS),
    .ROWS_OUT     (TB_ROWS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .window       (window),
    .window_valid (window_valid),
    .sxx          (sxx),
    .syy          (syy),
    .sxy          (sxy),
    .tensor_valid (tensor_valid),
    .out_col      (out_col),
    .out_row      (out_row),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint obs, input longint expv);
    total++;
    if (obs != expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Structure tensor straight from the Sobel definition, in plain integers.
  function automatic void modelTensor(input win_t w, output longint xx, output longint yy,
                                      output longint xy);
    int p [6][6];
    int gx, gy;
    for (int r = 0; r < 6; r++)
      for (int q = 0; q < 6; q++)
        p[r][q] = int'(w[r][q]);
    xx = 0; yy = 0; xy = 0;
    for (int r = 1; r <= 4; r++) begin
      for (int c = 1; c <= 4; c++) begin
        gx = (p[r-1][c+1] + 2*p[r][c+1] + p[r+1][c+1]) - (p[r-1][c-1] + 2*p[r][c-1] + p[r+1][c-1]);
        gy = (p[r+1][c-1] + 2*p[r+1][c] + p[r+1][c+1]) - (p[r-1][c-1] + 2*p[r-1][c] + p[r-1][c+1]);
        xx += longint'(gx * gx);
        yy += longint'(gy * gy);
        xy += longint'(gx * gy);
      end
    end
  endfunction

  // Drive one cycle; a valid window is queued with its expected tensor and raster position.
  task automatic applyStimulus(input win_t w, input bit vld, input longint xx, input longint yy,
                               input longint xy);
    exp_t e;
    @(posedge clk);
    #1;
    window       = w;
    window_valid = vld;
    if (vld) begin
      e.due = cyc + LAT;
      e.xx  = xx;
      e.yy  = yy;
      e.xy  = xy;
      e.col = pos_col;
      e.row = pos_row;
      e.fd  = (pos_col == TB_COLS-1) && (pos_row == TB_ROWS-1);
      expq.push_back(e);
      if (pos_col == TB_COLS-1) begin
        pos_col = 0;
        pos_row = (pos_row == TB_ROWS-1) ? 0 : pos_row + 1;
      end else begin
        pos_col++;
      end
    end
  endtask

  task automatic applyRandom(input bit vld);
    win_t   w;
    longint xx, yy, xy;
    bit     extreme;
    extreme = ($urandom_range(3) == 0);
    for (int r = 0; r < 6; r++)
      for (int q = 0; q < 6; q++)
        w[r][q] = extreme ? ($urandom_range(1) ? 8'd255 : 8'd0) : 8'($urandom_range(255));
    modelTensor(w, xx, yy, xy);
    applyStimulus(w, vld, xx, yy, xy);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        checkOutput("tensor_valid", tensor_valid, 1);
        checkOutput("sxx", sxx, e.xx);
        checkOutput("syy", syy, e.yy);
        checkOutput("sxy", sxy, e.xy);
        checkOutput("out_col", out_col, e.col);
        checkOutput("out_row", out_row, e.row);
        checkOutput("frame_done", frame_done, e.fd);
      end else begin
        checkOutput("idle_valid", tensor_valid, 0);
        checkOutput("idle_frame_done", frame_done, 0);
      end
      if (frame_done) fd_seen++;
    end
  end

  initial begin
    win_t w;
    int   sent;
    reset        = 1'b0;
    window_valid = 1'b0;
    window       = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", tensor_valid, 0);
    checkOutput("rst_sxx", sxx, 0);
    checkOutput("rst_syy", syy, 0);
    checkOutput("rst_sxy", sxy, 0);
    checkOutput("rst_col", out_col, 0);
    checkOutput("rst_row", out_row, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    reset    = 1'b1;
    checking = 1'b1;

    // Directed patterns with hand-derived tensors, each followed by idle cycles.
    for (int r = 0; r < 6; r++) for (int q = 0; q < 6; q++) w[r][q] = 8'd100;
    applyStimulus(w, 1'b1, 0, 0, 0);
    repeat (5) applyStimulus(w, 1'b0, 0, 0, 0);
    for (int r = 0; r < 6; r++) for (int q = 0; q < 6; q++) w[r][q] = 8'(10*q);
    applyStimulus(w, 1'b1, 102400, 0, 0);
    repeat (2) applyStimulus(w, 1'b0, 0, 0, 0);
    for (int r = 0; r < 6; r++) for (int q = 0; q < 6; q++) w[r][q] = 8'(10*r);
    applyStimulus(w, 1'b1, 0, 102400, 0);
    for (int r = 0; r < 6; r++) for (int q = 0; q < 6; q++) w[r][q] = 8'(100 + 10*q - 10*r);
    applyStimulus(w, 1'b1, 102400, 102400, -102400);
    for (int r = 0; r < 6; r++) for (int q = 0; q < 6; q++) w[r][q] = (q >= 3) ? 8'd255 : 8'd0;
    applyStimulus(w, 1'b1, 8323200, 0, 0);

    // Random traffic with gaps: fills the first frame exactly, then wraps into the next.
    sent = 5;
    while (sent < TB_COLS*TB_ROWS + 20) begin
      if ($urandom_range(3) != 0) begin
        applyRandom(1'b1);
        sent++;
      end else begin
        applyRandom(1'b0);
      end
    end

    // Three windows in flight when reset hits; none of them may surface.
    repeat (3) applyRandom(1'b1);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    window_valid = 1'b0;
    expq.delete();
    pos_col = 0;
    pos_row = 0;
    #1;
    checkOutput("midrst_valid", tensor_valid, 0);
    checkOutput("midrst_col", out_col, 0);
    checkOutput("midrst_row", out_row, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) applyRandom(1'b0);
    repeat (5) applyRandom(1'b1);

    for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_pending", expq.size(), 0);
    checkOutput("frame_done_count", fd_seen, 1);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
